// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-channel idle-timeout clock gating with latch ICGs and gated-cycle counters
module clk_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    test_en,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       busy,
  input  logic                    cnt_clr,
  output logic [NUM_CH-1:0]       gated_clk,
  output logic [NUM_CH-1:0]       ch_on,
  output logic [NUM_CH*CNT_W-1:0] gated_cnt
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] LAST = IW'(IDLE_CYCLES - 1);
  typedef enum logic {ACTIVE, GATED} state_t;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] cnt_q;
    logic en_raw, lat, on_q;
    assign en_raw = reset | test_en | (ch_en[i] & (busy[i] | state_q == ACTIVE));
    // Enable is captured while clk is low, so the high phase of gated_clk can never be cut short.
    always_latch if (!clk) lat <= en_raw;
    assign gated_clk[i] = clk & lat;
    assign ch_on[i] = on_q;
    assign gated_cnt[i*CNT_W +: CNT_W] = cnt_q;
    always_comb begin
      state_d = !ch_en[i] ? GATED :
                state_q == GATED ? (busy[i] ? ACTIVE : GATED) :
                (!busy[i] && idle_q == LAST) ? GATED : ACTIVE;
      idle_d = (ch_en[i] && state_q == ACTIVE && !busy[i] && idle_q != LAST) ? idle_q + 1'b1 : '0;
    end
    always_ff @(posedge clk)
      if (reset) begin
        state_q <= ACTIVE;
        idle_q  <= '0;
        on_q    <= 1'b1;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        on_q    <= state_d == ACTIVE;
        cnt_q   <= cnt_clr ? '0 : (!lat && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      end
  end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed checks of gating, wake, test override, reset clocking and counters
module tb_clk_gate_ctrl;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  logic clk = 1'b0, reset, test_en, cnt_clr;
  logic [NUM_CH-1:0] ch_en, busy, gated_clk, ch_on;
  logic [NUM_CH*CNT_W-1:0] gated_cnt;
  int n_cmp = 0, n_bad = 0, glitches = 0;

  clk_gate_ctrl #(.NUM_CH(NUM_CH), .IDLE_CYCLES(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .test_en(test_en), .ch_en(ch_en), .busy(busy),
    .cnt_clr(cnt_clr), .gated_clk(gated_clk), .ch_on(ch_on), .gated_cnt(gated_cnt)
  );

  always #5 clk = ~clk;

  // Half-cycle monitor: gated clock must be flat through each high phase and low in each low phase.
  always begin
    logic [NUM_CH-1:0] hi;
    @(posedge clk);
    #1 hi = gated_clk;
    #3 if (gated_clk !== hi) glitches++;
    @(negedge clk);
    #1 if (gated_clk !== '0) glitches++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; test_en = 0; cnt_clr = 0; ch_en = '0; busy = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (gated_clk !== 4'hF) begin n_bad++; $display("FAIL reset_clk edge %0d: got %h want f", k, gated_clk); end
    end
    n_cmp++; if (ch_on !== 4'hF) begin n_bad++; $display("FAIL reset_ch_on: got %h want f", ch_on); end
    n_cmp++; if (gated_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0000", gated_cnt); end
    reset = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (gated_clk !== 4'h0) begin n_bad++; $display("FAIL post_reset_clk %0d: got %h want 0", k, gated_clk); end
      n_cmp++; if (ch_on !== 4'h0) begin n_bad++; $display("FAIL post_reset_ch_on %0d: got %h want 0", k, ch_on); end
      n_cmp++; if (gated_cnt !== {4{4'(k)}}) begin n_bad++; $display("FAIL post_reset_cnt %0d: got %h want %h", k, gated_cnt, {4{4'(k)}}); end
    end
  endtask

  task automatic test_idle_timeout();
    ch_en = 4'hF; busy = 4'b0001; cnt_clr = 1;
    tick();
    n_cmp++; if (gated_clk !== 4'b0001) begin n_bad++; $display("FAIL idle_edge0_clk: got %h want 1", gated_clk); end
    n_cmp++; if (gated_cnt !== 16'h0) begin n_bad++; $display("FAIL idle_clr: got %h want 0000", gated_cnt); end
    busy = 0; cnt_clr = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (gated_clk[0] !== 1'b1) begin n_bad++; $display("FAIL idle_run_clk edge %0d: got %b want 1", k, gated_clk[0]); end
      n_cmp++; if (ch_on[0] !== (k < 8)) begin n_bad++; $display("FAIL idle_ch_on edge %0d: got %b want %b", k, ch_on[0], k < 8); end
    end
    for (int k = 9; k <= 13; k++) begin
      tick();
      n_cmp++; if (gated_clk[0] !== 1'b0) begin n_bad++; $display("FAIL idle_stop_clk edge %0d: got %b want 0", k, gated_clk[0]); end
    end
    n_cmp++; if (gated_cnt !== 16'hDDD5) begin n_bad++; $display("FAIL idle_cnt: got %h want ddd5", gated_cnt); end
  endtask

  task automatic test_wake();
    busy = 4'b0001;
    tick();
    n_cmp++; if (gated_clk !== 4'b0001) begin n_bad++; $display("FAIL wake_clk: got %h want 1", gated_clk); end
    n_cmp++; if (ch_on !== 4'b0001) begin n_bad++; $display("FAIL wake_ch_on: got %h want 1", ch_on); end
    n_cmp++; if (gated_cnt !== 16'hEEE5) begin n_bad++; $display("FAIL wake_cnt: got %h want eee5", gated_cnt); end
    ch_en = 4'b1110;
    tick();
    n_cmp++; if (gated_clk !== 4'h0) begin n_bad++; $display("FAIL ch_en_off_clk: got %h want 0", gated_clk); end
    n_cmp++; if (ch_on !== 4'h0) begin n_bad++; $display("FAIL ch_en_off_ch_on: got %h want 0", ch_on); end
    n_cmp++; if (gated_cnt !== 16'hFFF6) begin n_bad++; $display("FAIL ch_en_off_cnt: got %h want fff6", gated_cnt); end
    ch_en = 4'hF; busy = 0;
  endtask

  task automatic test_busy_toggle();
    int missed = 0;
    busy = 4'b0010; cnt_clr = 1;
    tick();
    cnt_clr = 0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 8; k++) begin
        busy[1] = (k == 7);
        tick();
        if (gated_clk[1] !== 1'b1) missed++;
      end
    n_cmp++; if (missed !== 0) begin n_bad++; $display("FAIL toggle_missed_edges: got %0d want 0", missed); end
    n_cmp++; if (ch_on[1] !== 1'b1) begin n_bad++; $display("FAIL toggle_ch_on: got %b want 1", ch_on[1]); end
    n_cmp++; if (gated_cnt !== 16'hFF0F) begin n_bad++; $display("FAIL toggle_cnt: got %h want ff0f", gated_cnt); end
    busy = 4'hF; ch_en = 4'h0;
    tick();
    n_cmp++; if (gated_clk !== 4'h0) begin n_bad++; $display("FAIL chen_vs_busy_clk: got %h want 0", gated_clk); end
    n_cmp++; if (ch_on !== 4'h0) begin n_bad++; $display("FAIL chen_vs_busy_ch_on: got %h want 0", ch_on); end
    busy = 0; ch_en = 4'hF;
  endtask

  task automatic test_test_en();
    cnt_clr = 1;
    tick();
    cnt_clr = 0; test_en = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (gated_clk !== 4'hF) begin n_bad++; $display("FAIL test_en_clk %0d: got %h want f", k, gated_clk); end
    end
    n_cmp++; if (gated_cnt !== 16'h0) begin n_bad++; $display("FAIL test_en_cnt: got %h want 0000", gated_cnt); end
    n_cmp++; if (ch_on !== 4'h0) begin n_bad++; $display("FAIL test_en_ch_on: got %h want 0", ch_on); end
    test_en = 0;
    tick();
    n_cmp++; if (gated_clk !== 4'h0) begin n_bad++; $display("FAIL test_en_off_clk: got %h want 0", gated_clk); end
    n_cmp++; if (gated_cnt !== 16'h1111) begin n_bad++; $display("FAIL test_en_off_cnt: got %h want 1111", gated_cnt); end
  endtask

  task automatic test_saturate();
    repeat (20) tick();
    n_cmp++; if (gated_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt: got %h want ffff", gated_cnt); end
    cnt_clr = 1;
    tick();
    n_cmp++; if (gated_cnt !== 16'h0) begin n_bad++; $display("FAIL sat_clr: got %h want 0000", gated_cnt); end
    cnt_clr = 0;
    tick();
    n_cmp++; if (gated_cnt !== 16'h1111) begin n_bad++; $display("FAIL sat_resume: got %h want 1111", gated_cnt); end
    n_cmp++; if (glitches !== 0) begin n_bad++; $display("FAIL glitch_monitor: got %0d want 0", glitches); end
  endtask

  initial begin
    test_reset();
    test_idle_timeout();
    test_wake();
    test_busy_toggle();
    test_test_en();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Multi-channel clock-gating controller for the PE array.
- Each channel drives one gated clock to a PE sub-block (scratchpads, MAC, PSum path).
- A channel's clock is turned off automatically after a programmable number of consecutive idle cycles, and back on with zero-cycle wake latency.
- Adds a per-channel software enable, a scan/test override, reset-time forced clocking and per-channel gated-cycle statistics counters.

Parameters:
- NUM_CH, 4: number of gated clock channels (1..16).
- IDLE_CYCLES, 8: consecutive idle rising edges before a channel gates off (1..255).
- CNT_W, 16: width of each per-channel gated-cycle statistics counter.

Ports:
- clk  input  1  free-running source clock.
- reset  input  1  synchronous, active-high reset.
- test_en  input  1  scan/test override; forces every channel's clock on.
- ch_en  input  NUM_CH  per-channel software enable; 0 keeps that channel gated.
- busy  input  NUM_CH  per-channel activity request from the sub-block or its controller.
- cnt_clr  input  1  synchronous clear of all statistics counters.
- gated_clk  output  NUM_CH  per-channel gated clocks.
- ch_on  output  NUM_CH  registered status; 1 means the channel is not in the GATED state.
- gated_cnt  output  NUM_CH*CNT_W  flattened saturating counters; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Per-channel state: ACTIVE or GATED, plus idle counter idle_q of width clog2(IDLE_CYCLES+1).
- Raw enable: en_raw[i] = reset | test_en | (ch_en[i] & (busy[i] | state[i]==ACTIVE)).
- Each channel has its own latch-based ICG:
  - The latch is transparent while clk is low and captures en_raw[i].
  - gated_clk[i] = clk & latch[i].
  - No flop-based or combinational-only gating; the output must be glitch-free.
- Wake timing:
  - busy[i] rising during a GATED cycle (before the falling edge) delivers the very next rising edge to that channel.
  - Wake latency is therefore 0 cycles.
- Transitions, evaluated on the clk rising edge:
  - ACTIVE, busy=1: idle_q <= 0.
  - ACTIVE, busy=0: idle_q <= idle_q+1. When idle_q == IDLE_CYCLES-1, go to GATED and clear idle_q.
  - Result: exactly IDLE_CYCLES edges with busy low are still delivered; the following edge is suppressed.
  - GATED, busy=1 and ch_en=1: go to ACTIVE, idle_q <= 0.
  - ch_en[i]=0 in any state: go to GATED, idle_q <= 0. The clock is suppressed from the next edge unless test_en=1.
  - test_en does not alter state or idle_q; it only overrides en_raw. Deasserting test_en restores gating from the current state.
- Reset (synchronous):
  - All states go to ACTIVE, idle_q <= 0, gated_cnt <= 0, ch_on <= all 1s.
  - en_raw is forced to 1 while reset is high, so downstream synchronous resets receive clock edges.
  - Reset asserted mid-countdown or while GATED aborts gating; the clock runs from the next edge.
- ch_on[i]: registered copy of (state==ACTIVE), updated on the same edge as the state.
- Statistics counters:
  - gated_cnt[i] increments on each clk rising edge where latch[i]==0, i.e. each suppressed edge.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority over increment; reset has priority over both.
- Simultaneous events:
  - busy rise on the same edge idle_q hits its terminal value: busy wins, and the channel stays ACTIVE.
  - ch_en=0 together with busy=1: ch_en wins, and the channel goes GATED.
- Channels are fully independent; no cross-channel interaction apart from test_en, reset and cnt_clr.

Test Plan:
- Reset with busy=0, ch_en=0 held for 3 cycles -> gated_clk toggles on all 3 edges; after release, ch_on=0 from the next edge, gated_cnt counts suppressed edges 1,2,3...
- IDLE_CYCLES=8, ch_en=F, busy[0] high then low at edge 0 -> ch0 gets 8 more edges then stops; ch_on[0] falls at edge 8; gated_cnt[0]=5 after 5 further edges.
- Channel GATED, busy[0] rises mid-cycle -> gated_clk[0] pulses on the very next rising edge; ch_on[0]=1 after that edge. No high-phase glitch on the clock, checked with a half-cycle resolution monitor.
- busy[1] toggled low for 7 cycles then high, repeated -> ch1 never gates; gated_cnt[1] stays 0.
- test_en=1 while all channels are GATED -> all clocks run and gated_cnt stays frozen. test_en=0 -> clocks stop on the next edge; state is unchanged.
- CNT_W=4 with a channel gated for 20 edges -> gated_cnt reads 15. cnt_clr pulse -> 0 on the next edge, then counting resumes at 1.
